// File: rtl/watchdog_monitor_if.sv
// Control, limit and status signals between a supervisor and the windowed watchdog.
// Signal names carry the direction seen from the watchdog.
interface watchdog_monitor_if #(
   parameter int CW = 16
);
   logic          i_en;
   logic          i_kick;
   logic          i_clr;
   logic [CW-1:0] i_timeout;
   logic [CW-1:0] i_win_open;
   logic          o_wdfail;
   logic [1:0]    o_fail_cause;
   logic          o_kick_ack;
   logic          o_win_ok;

   modport master (
      output i_en, i_kick, i_clr, i_timeout, i_win_open,
      input  o_wdfail, o_fail_cause, o_kick_ack, o_win_ok
   );

   modport slave (
      input  i_en, i_kick, i_clr, i_timeout, i_win_open,
      output o_wdfail, o_fail_cause, o_kick_ack, o_win_ok
   );
endinterface

// File: rtl/watchdog_monitor.sv
// Windowed watchdog: a heartbeat must arrive after the window opens and before the timeout.
// o_wdfail feeds the enable of the downstream reset-delay counter.
module watchdog_monitor #(
   parameter int CW = 16
) (
   input logic                i_clk,
   input logic                i_rst_n,
   watchdog_monitor_if.slave  wd
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FAIL = 2'd2
   } state_t;

   localparam logic [CW-1:0] CNT_MAX     = '1;
   localparam logic [1:0]    CAUSE_NONE  = 2'b00;
   localparam logic [1:0]    CAUSE_TMO   = 2'b01;
   localparam logic [1:0]    CAUSE_EARLY = 2'b10;

   state_t        r_state, w_state_next;
   logic [CW-1:0] r_cnt, w_cnt_next;
   logic [CW-1:0] r_tmo, w_tmo_next;
   logic [CW-1:0] r_win, w_win_next;
   logic [1:0]    r_cause, w_cause_next;
   logic          r_wdfail, w_wdfail_next;
   logic          r_ack, w_ack_next;
   logic          r_s1, r_s2, r_s3;
   logic          w_kick_evt;

   // Heartbeat is asynchronous: two flops for metastability, the third for edge detection.
   assign w_kick_evt = r_s2 & ~r_s3;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= wd.i_kick;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_tmo    <= '0;
         r_win    <= '0;
         r_cause  <= CAUSE_NONE;
         r_wdfail <= 1'b0;
         r_ack    <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_tmo    <= w_tmo_next;
         r_win    <= w_win_next;
         r_cause  <= w_cause_next;
         r_wdfail <= w_wdfail_next;
         r_ack    <= w_ack_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_tmo_next   = r_tmo;
      w_win_next   = r_win;
      w_cause_next = r_cause;
      w_ack_next   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_next   = '0;
            w_cause_next = CAUSE_NONE;
            if (wd.i_en) begin
               w_state_next = ST_RUN;
               w_tmo_next   = wd.i_timeout;
               w_win_next   = wd.i_win_open;
            end
         end
         ST_RUN: begin
            // A valid kick outranks a coincident timeout.
            if (!wd.i_en) begin
               w_state_next = ST_IDLE;
               w_cnt_next   = '0;
               w_cause_next = CAUSE_NONE;
            end else if (w_kick_evt && (r_cnt < r_win)) begin
               w_state_next = ST_FAIL;
               w_cause_next = CAUSE_EARLY;
            end else if (w_kick_evt) begin
               w_cnt_next = '0;
               w_ack_next = 1'b1;
            end else if (r_cnt == r_tmo) begin
               w_state_next = ST_FAIL;
               w_cause_next = CAUSE_TMO;
            end else if (r_cnt != CNT_MAX) begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_FAIL: begin
            if (!wd.i_en) begin
               w_state_next = ST_IDLE;
               w_cnt_next   = '0;
               w_cause_next = CAUSE_NONE;
            end else if (wd.i_clr) begin
               w_state_next = ST_RUN;
               w_cnt_next   = '0;
               w_tmo_next   = wd.i_timeout;
               w_win_next   = wd.i_win_open;
               w_cause_next = CAUSE_NONE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
            w_cause_next = CAUSE_NONE;
         end
      endcase
      w_wdfail_next = (w_state_next == ST_FAIL);
   end

   assign wd.o_wdfail     = r_wdfail;
   assign wd.o_fail_cause = r_cause;
   assign wd.o_kick_ack   = r_ack;
   assign wd.o_win_ok     = (r_state == ST_RUN) && (r_cnt >= r_win);
endmodule

// File: tb/tb_watchdog_monitor.sv
// Directed bench for watchdog_monitor: service, timeout, early kick, boundary and abort paths.
// Outputs are sampled on the falling edge; expected values are hand-derived constants.
module tb_watchdog_monitor;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   int   ack_total = 0;
   int   a0;

   always #5 clk = ~clk;

   watchdog_monitor_if #(.CW(CW)) wd ();

   watchdog_monitor #(.CW(CW)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .wd      (wd)
   );

   always @(negedge clk) begin
      if (wd.o_kick_ack === 1'b1) ack_total++;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end else begin
         $display("ok   %s: %0d (t=%0t)", tag, obs, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Ends on the falling edge right after the arming edge (cnt = 0).
   task automatic arm(input logic [CW-1:0] tmo, input logic [CW-1:0] win);
      wd.i_en = 1'b0;
      step(1);
      wd.i_timeout  = tmo;
      wd.i_win_open = win;
      wd.i_en       = 1'b1;
      step(1);
   endtask

   // Starting one half-cycle after a cnt=0 edge, produces a kick seen when cnt == c (c >= 3),
   // and ends on the falling edge right after the edge that acts on it.
   task automatic kick_at(input int c);
      step(c - 2);
      wd.i_kick = 1'b1;
      step(2);
      wd.i_kick = 1'b0;
      step(1);
   endtask

   initial begin
      rst_n         = 1'b1;
      wd.i_en       = 1'b0;
      wd.i_kick     = 1'b0;
      wd.i_clr      = 1'b0;
      wd.i_timeout  = '0;
      wd.i_win_open = '0;

      // Reset and idle
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_wdfail", wd.o_wdfail, 0);
      check_val("rst_cause", wd.o_fail_cause, 0);
      check_val("rst_ack", wd.o_kick_ack, 0);
      check_val("rst_winok", wd.o_win_ok, 0);
      step(2);
      rst_n = 1'b1;
      step(1);
      a0 = ack_total;
      wd.i_kick = 1'b1;
      step(3);
      wd.i_kick = 1'b0;
      step(4);
      check_val("idle_ack_count", ack_total - a0, 0);
      check_val("idle_wdfail", wd.o_wdfail, 0);
      check_val("idle_winok", wd.o_win_ok, 0);

      // Normal service: 10 kicks, each 10 cycles apart
      arm(20, 5);
      check_val("svc_winok_cnt0", wd.o_win_ok, 0);
      a0 = ack_total;
      for (int i = 0; i < 10; i++) begin
         kick_at(9);
         check_val($sformatf("svc_ack_%0d", i), wd.o_kick_ack, 1);
         check_val($sformatf("svc_wdfail_%0d", i), wd.o_wdfail, 0);
      end
      step(1);
      check_val("svc_ack_width", wd.o_kick_ack, 0);
      check_val("svc_ack_count", ack_total - a0, 10);

      // Timeout, hold, clear and restart
      arm(20, 5);
      step(20);
      check_val("tmo_before", wd.o_wdfail, 0);
      step(1);
      check_val("tmo_wdfail", wd.o_wdfail, 1);
      check_val("tmo_cause", wd.o_fail_cause, 1);
      step(5);
      check_val("tmo_hold", wd.o_wdfail, 1);
      wd.i_clr = 1'b1;
      step(1);
      wd.i_clr = 1'b0;
      check_val("clr_wdfail", wd.o_wdfail, 0);
      check_val("clr_cause", wd.o_fail_cause, 0);
      check_val("clr_winok", wd.o_win_ok, 0);
      step(4);
      check_val("restart_winok_cnt4", wd.o_win_ok, 0);
      step(1);
      check_val("restart_winok_cnt5", wd.o_win_ok, 1);

      // Early kick, then kicks ignored in FAIL
      arm(20, 8);
      a0 = ack_total;
      kick_at(3);
      check_val("early_wdfail", wd.o_wdfail, 1);
      check_val("early_cause", wd.o_fail_cause, 2);
      check_val("early_ack", wd.o_kick_ack, 0);
      kick_at(3);
      check_val("fail_kick_wdfail", wd.o_wdfail, 1);
      check_val("fail_kick_ack_count", ack_total - a0, 0);

      // EN drop outranks CLR in FAIL
      wd.i_en  = 1'b0;
      wd.i_clr = 1'b1;
      step(1);
      wd.i_clr = 1'b0;
      check_val("abort_wdfail", wd.o_wdfail, 0);
      check_val("abort_cause", wd.o_fail_cause, 0);
      step(10);
      check_val("abort_idle_winok", wd.o_win_ok, 0);
      check_val("abort_idle_wdfail", wd.o_wdfail, 0);

      // Boundary: kick exactly at cnt == WIN_OPEN == TIMEOUT, then one cycle early
      arm(12, 12);
      kick_at(12);
      check_val("bnd_ack", wd.o_kick_ack, 1);
      check_val("bnd_wdfail", wd.o_wdfail, 0);
      kick_at(11);
      check_val("bnd_early_wdfail", wd.o_wdfail, 1);
      check_val("bnd_early_cause", wd.o_fail_cause, 2);
      check_val("bnd_early_ack", wd.o_kick_ack, 0);

      // Latched TIMEOUT governs despite a later change; WIN_OPEN=0 opens immediately
      arm(10, 0);
      check_val("win0_winok", wd.o_win_ok, 1);
      wd.i_timeout = 30;
      step(10);
      check_val("latch_before", wd.o_wdfail, 0);
      step(1);
      check_val("latch_wdfail", wd.o_wdfail, 1);
      check_val("latch_cause", wd.o_fail_cause, 1);

      // TIMEOUT=0 fails on the first RUN cycle
      arm(0, 0);
      check_val("tmo0_armed", wd.o_wdfail, 0);
      step(1);
      check_val("tmo0_wdfail", wd.o_wdfail, 1);
      check_val("tmo0_cause", wd.o_fail_cause, 1);

      // Asynchronous reset mid-RUN
      arm(20, 0);
      check_val("arst_run_pre", wd.o_win_ok, 1);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_run_winok", wd.o_win_ok, 0);
      check_val("arst_run_wdfail", wd.o_wdfail, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1);

      // Asynchronous reset mid-FAIL
      arm(0, 0);
      step(1);
      check_val("arst_fail_pre", wd.o_wdfail, 1);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_fail_wdfail", wd.o_wdfail, 0);
      check_val("arst_fail_cause", wd.o_fail_cause, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/watchdog_monitor.md
# watchdog_monitor

Windowed watchdog that supervises a heartbeat (KICK) from the monitored processor and raises WDFAIL when the heartbeat is missing or too early. Sits directly upstream of the reset-delay counter stage: WDFAIL is that stage's enable input. WDFAIL high makes the downstream stage count toward its reset limit. WDFAIL low clears that stage and releases its reset output.

## Interface
- CW, 16, width of timeout/window counter and limit inputs
- CLK  input  1  system clock, all state on rising edge
- RST_N  input  1  asynchronous active-low reset
- EN  input  1  watchdog enable, level
- KICK  input  1  heartbeat from monitored logic, asynchronous, edge-significant (rising edge = kick)
- CLR  input  1  failure acknowledge, synchronous, sampled only in FAIL
- TIMEOUT  input  CW  cycles allowed between arming/kick and next kick
- WIN_OPEN  input  CW  earliest counter value at which a kick is legal
- WDFAIL  output  1  failure flag to downstream reset stage, registered
- FAIL_CAUSE  output  2  01 timeout, 10 early kick, 00 none, registered
- KICK_ACK  output  1  one-cycle pulse on each accepted kick, registered
- WIN_OK  output  1  high while RUN and cnt >= WIN_OPEN (kick would be accepted)

## Operation
- Reset: one clock, reset asynchronous and active-low (CLK, RST_N). Reset clears all state asynchronously: state=IDLE, cnt=0, sync flops=0, WDFAIL=0, FAIL_CAUSE=00, KICK_ACK=0, WIN_OK=0.
- KICK sync: 3-flop chain s1,s2,s3. Kick event k = s2 & ~s3.
- Limits: TIMEOUT and WIN_OPEN are latched into tmo_q/win_q on the IDLE->RUN transition. Later changes are ignored until the next arming.
- States: IDLE, RUN, FAIL.
- IDLE: cnt=0, outputs low. EN=1 -> RUN, latch limits, cnt=0.
- RUN: cnt increments by 1 per cycle and saturates at all-ones. Priority from highest to lowest:
  1. EN=0 -> IDLE.
  2. k && cnt < win_q -> FAIL, FAIL_CAUSE=10.
  3. k && cnt >= win_q -> accept: cnt=0, KICK_ACK=1 next cycle.
  4. cnt == tmo_q -> FAIL, FAIL_CAUSE=01.
- FAIL: WDFAIL=1, FAIL_CAUSE held, cnt frozen, kicks ignored (KICK_ACK stays 0).
  - EN=0 -> IDLE, clears WDFAIL and FAIL_CAUSE.
  - CLR=1 -> RUN, cnt=0, relatch limits, clears WDFAIL and FAIL_CAUSE.
  - EN=0 has priority over CLR.
- CLR is ignored in IDLE and RUN.
- WIN_OPEN=0: no early window, every kick is valid.
- WIN_OPEN > TIMEOUT: every kick is early. This is legal; FAIL_CAUSE=10.
- TIMEOUT=0: FAIL on the first RUN cycle unless a valid kick coincides.
- Kick on the same cycle as cnt==tmo_q with cnt>=win_q: the kick wins, no failure.
- Width rules: cnt, tmo_q and win_q are all CW bits. Comparisons are unsigned.

## Timing
- KICK rising before edge N: s1 set at N, k high during the cycle after N+1, acted on at edge N+2. KICK_ACK/WDFAIL are visible after edge N+2.
- KICK must stay high ≥2 CLK cycles and low ≥2 cycles between kicks. Shorter pulses may be lost.
- Timeout: after arming or an accepted kick at edge E (cnt=0 after E), WDFAIL rises after edge E+tmo_q+1.
- All outputs are registered and change only on CLK rising edge, except on async reset.
- KICK_ACK is exactly 1 cycle wide.
- WIN_OK derives from the registered state and cnt. It may be combinational from them, but no input reaches it combinationally.
- EN falling: IDLE and outputs low after the next edge. A simultaneous kick or timeout is discarded.
- RST_N asserted mid-RUN or mid-FAIL: outputs go to 0 immediately, independent of CLK. Deassertion is synchronized externally.

## Test plan
- Reset/idle: RST_N low then high, EN=0, pulse KICK -> all outputs 0, KICK_ACK never pulses.
- Normal service: TIMEOUT=20, WIN_OPEN=5, EN=1, kick every 10 cycles for 10 kicks -> 10 KICK_ACK pulses, WDFAIL stays 0.
- Timeout: TIMEOUT=20, WIN_OPEN=5, no kick after arming at edge E -> WDFAIL=1 and FAIL_CAUSE=01 after edge E+21. WDFAIL holds until CLR; CLR -> WDFAIL=0 next edge, counting restarts.
- Early kick: WIN_OPEN=8, kick processed at cnt=3 -> WDFAIL=1, FAIL_CAUSE=10, no KICK_ACK.
- Boundary coincidence: TIMEOUT=12, WIN_OPEN=12, kick processed exactly at cnt=12 -> KICK_ACK=1, no failure. Kick at cnt=11 -> FAIL, FAIL_CAUSE=10.
- Abort paths:
  - EN dropped in FAIL while CLR=1 -> IDLE, WDFAIL=0.
  - RST_N asserted mid-RUN -> outputs 0 with no clock edge.
  - TIMEOUT changed during RUN -> old limit still governs.
